decode_stage: RTL and testbench

- Registered, DECODE_WIDTH-wide instruction decode stage between fetch and reservation-station dispatch.
- Each cycle it accepts one fetch bundle of up to DECODE_WIDTH 32-bit instructions under a valid/ready handshake and decodes every lane in parallel.
- It presents the decoded micro-op bundle from a single output register, with flush support and illegal-instruction flagging.
- Every decoded field is fully defined for every opcode, including unknown ones.

---
 rtl/decode_pkg.sv | 40 ++++
 rtl/decode_lane.sv | 86 ++++++++
 rtl/decode_stage.sv | 77 +++++++
 tb/tb_decode_stage.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// rtl/decode_pkg.sv - opcodes, reservation-station ids and micro-op layout for decode
package decode_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_ADDIU   = 6'b001001;
   localparam logic [5:0] OP_ANDI    = 6'b001100;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;

   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_AND  = 6'b100100;
   localparam logic [5:0] FN_DIV  = 6'b011010;
   localparam logic [5:0] FN_MFHI = 6'b010000;
   localparam logic [5:0] FN_MFLO = 6'b010010;

   typedef enum logic [3:0] {
      RS_NONE   = 4'd0,
      RS_ALU    = 4'd1,
      RS_MULDIV = 4'd2,
      RS_BRANCH = 4'd3,
      RS_LSU    = 4'd4
   } rs_station_e;

   typedef struct packed {
      logic [3:0]  station;
      logic [5:0]  alu_fn;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [15:0] imm;
      logic        has_rs1;
      logic        has_rs2;
      logic        has_rd;
      logic        illegal;
   } uop_t;

   localparam int UOP_W = $bits(uop_t);

endpackage

// File: rtl/decode_lane.sv
// rtl/decode_lane.sv - combinational decode of one 32-bit instruction into a uop
import decode_pkg::*;

module decode_lane (
   input  logic [31:0] instr,
   output uop_t        uop
);

   logic [5:0] op;
   logic [5:0] fn;

   assign op = instr[31:26];
   assign fn = instr[5:0];

   always_comb begin
      uop = '0;
      case (op)
         OP_ADDIU, OP_ANDI: begin
            uop.station = RS_ALU;
            uop.alu_fn  = (op == OP_ANDI) ? 6'd2 : 6'd0;
            uop.rs1     = instr[25:21];
            uop.rd      = instr[20:16];
            uop.imm     = instr[15:0];
            uop.has_rs1 = 1'b1;
            uop.has_rd  = 1'b1;
         end
         OP_BEQ: begin
            uop.station = RS_BRANCH;
            uop.alu_fn  = 6'd3;
            uop.rs1     = instr[25:21];
            uop.rs2     = instr[20:16];
            uop.imm     = instr[15:0];
            uop.has_rs1 = 1'b1;
            uop.has_rs2 = 1'b1;
         end
         OP_LW: begin
            uop.station = RS_LSU;
            uop.rs1     = instr[25:21];
            uop.rd      = instr[20:16];
            uop.imm     = instr[15:0];
            uop.has_rs1 = 1'b1;
            uop.has_rd  = 1'b1;
         end
         OP_SW: begin
            uop.station = RS_LSU;
            uop.alu_fn  = 6'd1;
            uop.rs1     = instr[25:21];
            uop.rs2     = instr[20:16];
            uop.imm     = instr[15:0];
            uop.has_rs1 = 1'b1;
            uop.has_rs2 = 1'b1;
         end
         OP_SPECIAL: begin
            case (fn)
               FN_ADDU, FN_AND: begin
                  uop.station = RS_ALU;
                  uop.alu_fn  = (fn == FN_AND) ? 6'd1 : 6'd0;
                  uop.rs1     = instr[25:21];
                  uop.rs2     = instr[20:16];
                  uop.rd      = instr[15:11];
                  uop.has_rs1 = 1'b1;
                  uop.has_rs2 = 1'b1;
                  uop.has_rd  = 1'b1;
               end
               // HI/LO are implicit, so div writes no architectural rd
               FN_DIV: begin
                  uop.station = RS_MULDIV;
                  uop.rs1     = instr[25:21];
                  uop.rs2     = instr[20:16];
                  uop.has_rs1 = 1'b1;
                  uop.has_rs2 = 1'b1;
               end
               FN_MFHI, FN_MFLO: begin
                  uop.station = RS_MULDIV;
                  uop.alu_fn  = (fn == FN_MFLO) ? 6'd2 : 6'd1;
                  uop.rd      = instr[15:11];
                  uop.has_rd  = 1'b1;
               end
               default: uop.illegal = 1'b1;
            endcase
         end
         default: uop.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered multi-lane decode stage between fetch and dispatch
import decode_pkg::*;

module decode_stage #(
   parameter int DECODE_WIDTH = 2,
   parameter int CNT_W        = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DECODE_WIDTH-1:0]       in_lane_valid,
   input  logic [DECODE_WIDTH*32-1:0]    in_instr,
   input  logic                          flush,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [DECODE_WIDTH-1:0]       out_lane_valid,
   output logic [DECODE_WIDTH*UOP_W-1:0] out_uop,
   output logic                          out_illegal_any,
   output logic [CNT_W-1:0]              decode_count
);

   logic                          accept;
   logic                          transfer;
   logic [DECODE_WIDTH*UOP_W-1:0] next_uop;
   logic [DECODE_WIDTH-1:0]       lane_illegal;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;
   assign transfer = out_valid && out_ready;

   for (genvar i = 0; i < DECODE_WIDTH; i++) begin : g_lane
      uop_t lane_uop;

      decode_lane u_decode_lane (
         .instr (in_instr[32*i +: 32]),
         .uop   (lane_uop)
      );

      assign next_uop[UOP_W*i +: UOP_W] = in_lane_valid[i] ? lane_uop : '0;
      assign lane_illegal[i]            = in_lane_valid[i] && lane_uop.illegal;
   end

   // An all-invalid bundle is consumed but presents nothing downstream
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid       <= 1'b0;
         out_lane_valid  <= '0;
         out_uop         <= '0;
         out_illegal_any <= 1'b0;
      end else if (flush) begin
         out_valid       <= 1'b0;
         out_lane_valid  <= '0;
         out_uop         <= '0;
         out_illegal_any <= 1'b0;
      end else if (accept) begin
         out_valid       <= |in_lane_valid;
         out_lane_valid  <= in_lane_valid;
         out_uop         <= next_uop;
         out_illegal_any <= |lane_illegal;
      end else if (transfer) begin
         out_valid       <= 1'b0;
         out_lane_valid  <= '0;
         out_uop         <= '0;
         out_illegal_any <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         decode_count <= '0;
      end else if (transfer && !flush) begin
         decode_count <= decode_count + CNT_W'($countones(out_lane_valid));
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage
import decode_pkg::*;

module tb_decode_stage;

   localparam int DW = 2;
   localparam int CW = 32;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic [DW-1:0]        in_lane_valid = '0;
   logic [DW*32-1:0]     in_instr = '0;
   logic                 flush = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b0;
   logic [DW-1:0]        out_lane_valid;
   logic [DW*UOP_W-1:0]  out_uop;
   logic                 out_illegal_any;
   logic [CW-1:0]        decode_count;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   decode_stage #(.DECODE_WIDTH(DW), .CNT_W(CW)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_lane_valid   (in_lane_valid),
      .in_instr        (in_instr),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_lane_valid  (out_lane_valid),
      .out_uop         (out_uop),
      .out_illegal_any (out_illegal_any),
      .decode_count    (decode_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference decode table: fields laid out in uop order, illegal in bit 0
   function automatic logic [UOP_W-1:0] ref_decode(input logic [31:0] x);
      logic [3:0]  st;
      logic [5:0]  alu;
      logic [4:0]  a, b, d;
      logic [15:0] im;
      logic        h1, h2, hd, ill;
      st = 0; alu = 0; a = 0; b = 0; d = 0; im = 0;
      h1 = 0; h2 = 0; hd = 0; ill = 0;
      case (x[31:26])
         6'h09, 6'h0C: begin
            st = 1; alu = (x[31:26] == 6'h0C) ? 6'd2 : 6'd0;
            a = x[25:21]; d = x[20:16]; im = x[15:0]; h1 = 1; hd = 1;
         end
         6'h04: begin st = 3; alu = 3; a = x[25:21]; b = x[20:16]; im = x[15:0]; h1 = 1; h2 = 1; end
         6'h23: begin st = 4; a = x[25:21]; d = x[20:16]; im = x[15:0]; h1 = 1; hd = 1; end
         6'h2B: begin st = 4; alu = 1; a = x[25:21]; b = x[20:16]; im = x[15:0]; h1 = 1; h2 = 1; end
         6'h00: begin
            case (x[5:0])
               6'h21, 6'h24: begin
                  st = 1; alu = (x[5:0] == 6'h24) ? 6'd1 : 6'd0;
                  a = x[25:21]; b = x[20:16]; d = x[15:11]; h1 = 1; h2 = 1; hd = 1;
               end
               6'h1A: begin st = 2; a = x[25:21]; b = x[20:16]; h1 = 1; h2 = 1; end
               6'h10: begin st = 2; alu = 1; d = x[15:11]; hd = 1; end
               6'h12: begin st = 2; alu = 2; d = x[15:11]; hd = 1; end
               default: ill = 1;
            endcase
         end
         default: ill = 1;
      endcase
      return {st, alu, a, b, d, im, h1, h2, hd, ill};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: case ($urandom_range(0, 4))
               0: r[31:26] = 6'h09;
               1: r[31:26] = 6'h0C;
               2: r[31:26] = 6'h04;
               3: r[31:26] = 6'h23;
               default: r[31:26] = 6'h2B;
            endcase
         1: begin
            r[31:26] = 6'h00;
            case ($urandom_range(0, 4))
               0: r[5:0] = 6'h21;
               1: r[5:0] = 6'h24;
               2: r[5:0] = 6'h1A;
               3: r[5:0] = 6'h10;
               default: r[5:0] = 6'h12;
            endcase
         end
         2: r[31:26] = 6'h00;
         default: ;
      endcase
      return r;
   endfunction

   // Behavioural model of the stage: a one-entry slot plus a lane counter
   bit             m_valid;
   logic [DW-1:0]  m_lv;
   logic [UOP_W-1:0] m_uop [DW];
   bit             m_ill;
   logic [CW-1:0]  m_count;
   bit             m_take, m_give;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid = 0; m_lv = '0; m_ill = 0; m_count = '0;
         for (int i = 0; i < DW; i++) m_uop[i] = '0;
      end else if (flush) begin
         m_valid = 0; m_lv = '0;
      end else begin
         m_give = m_valid && out_ready;
         m_take = in_valid && (!m_valid || out_ready);
         if (m_give)
            for (int i = 0; i < DW; i++) m_count = m_count + CW'(m_lv[i]);
         if (m_take) begin
            m_lv = in_lane_valid; m_valid = |in_lane_valid; m_ill = 0;
            for (int i = 0; i < DW; i++) begin
               m_uop[i] = in_lane_valid[i] ? ref_decode(in_instr[32*i +: 32]) : '0;
               if (m_uop[i][0]) m_ill = 1;
            end
         end else if (m_give) begin
            m_valid = 0; m_lv = '0;
         end
      end
   end

   always @(posedge clk) begin
      #2;
      if (!rst) begin
         chk("out_valid", 64'(out_valid), 64'(m_valid));
         chk("in_ready", 64'(in_ready), 64'(!m_valid || out_ready));
         chk("decode_count", 64'(decode_count), 64'(m_count));
         if (m_valid) begin
            chk("out_lane_valid", 64'(out_lane_valid), 64'(m_lv));
            chk("out_illegal_any", 64'(out_illegal_any), 64'(m_ill));
            for (int i = 0; i < DW; i++)
               chk("out_uop", 64'(out_uop[UOP_W*i +: UOP_W]), 64'(m_uop[i]));
         end
      end
   end

   task automatic put(input logic v, input logic [DW-1:0] lv, input logic [31:0] i1,
                      input logic [31:0] i0, input logic ordy, input logic fl);
      in_valid = v; in_lane_valid = lv; in_instr = {i1, i0}; out_ready = ordy; flush = fl;
      @(negedge clk);
   endtask

   initial begin
      uop_t                u;
      logic [DW*UOP_W-1:0] snap;
      logic [CW-1:0]       cnt0;

      u = ref_decode(32'h24220005);
      chk("model_addiu_station", 64'(u.station), 64'd1);
      chk("model_addiu_rd", 64'(u.rd), 64'd2);
      chk("model_addiu_imm", 64'(u.imm), 64'd5);
      u = ref_decode(32'h00003810);
      chk("model_mfhi", 64'({u.station, u.alu_fn, u.rd}), 64'({4'd2, 6'd1, 5'd7}));
      u = ref_decode(32'hFC000000);
      chk("model_illegal", 64'(u), 64'd1);

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_lane_valid", 64'(out_lane_valid), 64'd0);
      chk("rst_uop", 64'(out_uop[63:0]), 64'd0);
      chk("rst_uop_hi", 64'(out_uop[DW*UOP_W-1:64]), 64'd0);
      chk("rst_illegal_any", 64'(out_illegal_any), 64'd0);
      chk("rst_count", 64'(decode_count), 64'd0);
      rst = 1'b0;

      put(1, 2'b11, 32'h00221821, 32'h24220005, 1, 0);
      chk("t1_out_valid", 64'(out_valid), 64'd1);
      u = out_uop[0 +: UOP_W];
      chk("t1_l0", 64'({u.station, u.alu_fn, u.rs1, u.rd, u.imm}),
          64'({4'd1, 6'd0, 5'd1, 5'd2, 16'd5}));
      u = out_uop[UOP_W +: UOP_W];
      chk("t1_l1", 64'({u.station, u.alu_fn, u.rs1, u.rs2, u.rd}),
          64'({4'd1, 6'd0, 5'd1, 5'd2, 5'd3}));
      put(0, 2'b00, 0, 0, 1, 0);
      chk("t1_count", 64'(decode_count), 64'd2);

      put(1, 2'b01, 32'h8CA40008, 32'hFC000000, 1, 0);
      u = out_uop[0 +: UOP_W];
      chk("t2_l0_illegal", 64'(u.illegal), 64'd1);
      chk("t2_illegal_any", 64'(out_illegal_any), 64'd1);
      chk("t2_l1_zero", 64'(out_uop[UOP_W +: UOP_W]), 64'd0);
      put(0, 2'b00, 0, 0, 1, 0);
      chk("t2_count", 64'(decode_count), 64'd3);

      put(1, 2'b01, 0, 32'h00003810, 1, 0);
      u = out_uop[0 +: UOP_W];
      chk("t3_mfhi", 64'({u.station, u.alu_fn, u.rd, u.has_rd, u.has_rs1, u.has_rs2}),
          64'({4'd2, 6'd1, 5'd7, 3'b100}));
      put(0, 2'b00, 0, 0, 1, 0);
      chk("t3_count", 64'(decode_count), 64'd4);

      put(1, 2'b11, 32'h8CA40008, 32'h24220005, 0, 0);
      snap = out_uop;
      repeat (3) begin
         put(1, 2'b11, 32'h00003810, 32'h00221821, 0, 0);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_stable_lo", 64'(out_uop[63:0]), 64'(snap[63:0]));
         chk("bp_stable_hi", 64'(out_uop[DW*UOP_W-1:64]), 64'(snap[DW*UOP_W-1:64]));
      end
      put(1, 2'b11, 32'h00003810, 32'h00221821, 1, 0);
      chk("bp_no_bubble", 64'(out_valid), 64'd1);
      chk("bp_next_l0", 64'(out_uop[0 +: UOP_W]), 64'(ref_decode(32'h00221821)));
      chk("bp_count", 64'(decode_count), 64'd6);
      put(0, 2'b00, 0, 0, 1, 0);
      chk("bp_count2", 64'(decode_count), 64'd8);

      put(1, 2'b11, 32'hAC450004, 32'h10220003, 0, 0);
      cnt0 = decode_count;
      put(1, 2'b11, 32'h0022001A, 32'h00004012, 0, 1);
      chk("fl_out_valid", 64'(out_valid), 64'd0);
      chk("fl_lane_valid", 64'(out_lane_valid), 64'd0);
      chk("fl_count", 64'(decode_count), 64'(cnt0));
      put(0, 2'b00, 0, 0, 1, 0);
      chk("fl_dropped", 64'(out_valid), 64'd0);
      chk("fl_count2", 64'(decode_count), 64'(cnt0));

      repeat (500)
         put($urandom_range(0, 3) != 0, DW'($urandom), rand_instr(), rand_instr(),
             $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);

      put(1, 2'b11, 32'h24220005, 32'h24220005, 1, 0);
      put(1, 2'b11, 32'h24220005, 32'h24220005, 0, 0);
      chk("ar_pre_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("ar_out_valid", 64'(out_valid), 64'd0);
      chk("ar_count", 64'(decode_count), 64'd0);
      chk("ar_lane_valid", 64'(out_lane_valid), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      put(0, 2'b00, 0, 0, 1, 0);
      chk("ar_no_replay", 64'(out_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
